// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_M masters share one slave port, with LOCK
// holding, combinational return-path steering and a watchdog that ends hung cycles with ERR.
module wb_arbiter #(
  parameter int NUM_M   = 2,
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16,
  localparam int SEL_W  = DAT_W / 8
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [NUM_M-1:0]       M_CYC_I,
  input  logic [NUM_M-1:0]       M_STB_I,
  input  logic [NUM_M-1:0]       M_WE_I,
  input  logic [NUM_M-1:0]       M_LOCK_I,
  input  logic [NUM_M*ADR_W-1:0] M_ADR_I,
  input  logic [NUM_M*DAT_W-1:0] M_DAT_I,
  input  logic [NUM_M*SEL_W-1:0] M_SEL_I,
  input  logic [NUM_M*TAG_W-1:0] M_TGA_I,
  input  logic [NUM_M*TAG_W-1:0] M_TGC_I,
  input  logic [NUM_M*TAG_W-1:0] M_TGD_I,
  output logic [NUM_M-1:0]       M_ACK_O,
  output logic [NUM_M-1:0]       M_ERR_O,
  output logic [NUM_M-1:0]       M_RTY_O,
  output logic [DAT_W-1:0]       M_DAT_O,
  output logic [TAG_W-1:0]       M_TGD_O,
  output logic                   S_CYC_O,
  output logic                   S_STB_O,
  output logic                   S_WE_O,
  output logic                   S_LOCK_O,
  output logic [ADR_W-1:0]       S_ADR_O,
  output logic [DAT_W-1:0]       S_DAT_O,
  output logic [SEL_W-1:0]       S_SEL_O,
  output logic [TAG_W-1:0]       S_TGA_O,
  output logic [TAG_W-1:0]       S_TGC_O,
  output logic [TAG_W-1:0]       S_TGD_O,
  input  logic [DAT_W-1:0]       S_DAT_I,
  input  logic [TAG_W-1:0]       S_TGD_I,
  input  logic                   S_ACK_I,
  input  logic                   S_ERR_I,
  input  logic                   S_RTY_I,
  output logic [NUM_M-1:0]       GNT_O,
  output logic                   TIMEOUT_O
);

  localparam int LW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_reg, state_next;
  logic [NUM_M-1:0]  gnt_reg, gnt_next;
  logic [LW-1:0]     last_reg, last_next;
  logic [WD_W-1:0]   wdog_reg, wdog_next;
  logic              abort_reg, abort_next;

  logic              own;
  logic              term;
  logic              found;
  logic [LW-1:0]     idx;
  logic [LW-1:0]     pick;

  logic [ADR_W-1:0]  adr_arr [NUM_M];
  logic [DAT_W-1:0]  dat_arr [NUM_M];
  logic [SEL_W-1:0]  sel_arr [NUM_M];
  logic [TAG_W-1:0]  tga_arr [NUM_M];
  logic [TAG_W-1:0]  tgc_arr [NUM_M];
  logic [TAG_W-1:0]  tgd_arr [NUM_M];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_master
      assign adr_arr[gi] = M_ADR_I[gi*ADR_W +: ADR_W];
      assign dat_arr[gi] = M_DAT_I[gi*DAT_W +: DAT_W];
      assign sel_arr[gi] = M_SEL_I[gi*SEL_W +: SEL_W];
      assign tga_arr[gi] = M_TGA_I[gi*TAG_W +: TAG_W];
      assign tgc_arr[gi] = M_TGC_I[gi*TAG_W +: TAG_W];
      assign tgd_arr[gi] = M_TGD_I[gi*TAG_W +: TAG_W];
      // Only the granted master sees terminations; abort forces ERR for one cycle.
      assign M_ACK_O[gi] = gnt_reg[gi] & S_ACK_I & S_CYC_O;
      assign M_ERR_O[gi] = gnt_reg[gi] & ((S_ERR_I & S_CYC_O) | abort_reg);
      assign M_RTY_O[gi] = gnt_reg[gi] & S_RTY_I & S_CYC_O;
    end
  endgenerate

  // last_reg doubles as the mux select, since it always names the current owner in OWN.
  assign own       = (state_reg == OWN);
  assign S_CYC_O   = own & M_CYC_I[last_reg] & ~abort_reg;
  assign S_STB_O   = own & M_STB_I[last_reg] & M_CYC_I[last_reg] & ~abort_reg;
  assign S_WE_O    = own & M_WE_I[last_reg];
  assign S_LOCK_O  = own & M_LOCK_I[last_reg];
  assign S_ADR_O   = own ? adr_arr[last_reg] : '0;
  assign S_DAT_O   = own ? dat_arr[last_reg] : '0;
  assign S_SEL_O   = own ? sel_arr[last_reg] : '0;
  assign S_TGA_O   = own ? tga_arr[last_reg] : '0;
  assign S_TGC_O   = own ? tgc_arr[last_reg] : '0;
  assign S_TGD_O   = own ? tgd_arr[last_reg] : '0;
  assign M_DAT_O   = S_DAT_I;
  assign M_TGD_O   = S_TGD_I;
  assign GNT_O     = gnt_reg;
  assign TIMEOUT_O = abort_reg;

  assign term = (S_ACK_I | S_ERR_I | S_RTY_I) & S_CYC_O;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      last_reg  <= LW'(NUM_M - 1);
      wdog_reg  <= '0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
      wdog_reg  <= wdog_next;
      abort_reg <= abort_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    wdog_next  = '0;
    abort_next = 1'b0;
    found      = 1'b0;
    idx        = '0;
    pick       = '0;
    case (state_reg)
      IDLE: begin
        // Search starts just after the previous owner so every requester gets a turn.
        for (int k = 1; k <= NUM_M; k++) begin
          idx = LW'((int'(last_reg) + k) % NUM_M);
          if (!found && M_CYC_I[idx]) begin
            found = 1'b1;
            pick  = idx;
          end
        end
        if (found) begin
          state_next = OWN;
          gnt_next   = NUM_M'(1) << pick;
          last_next  = pick;
        end
      end
      OWN: begin
        if (!M_CYC_I[last_reg] && !M_LOCK_I[last_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
        end else if (TIMEOUT != 0 && S_STB_O && !term) begin
          if (wdog_reg == WD_LAST) abort_next = 1'b1;
          else                     wdog_next  = wdog_reg + WD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, fairness, single write, LOCK, watchdog and
// mid-transfer reset; a TIMEOUT=0 twin shares the stimulus to show the watchdog disabled.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_cyc, m_stb, m_we, m_lock;
  logic [63:0] m_adr, m_dat;
  logic [7:0]  m_sel, m_tga, m_tgc, m_tgd;
  logic [31:0] s_dat_i;
  logic [3:0]  s_tgd_i;
  logic        s_ack, s_err, s_rty;

  logic [1:0]  m_ack, m_err, m_rty, gnt;
  logic [31:0] m_dat_o, s_adr, s_dat_o;
  logic [3:0]  m_tgd_o, s_sel, s_tga, s_tgc, s_tgd_o;
  logic        s_cyc, s_stb, s_we, s_lock, tout;

  logic [1:0]  z_m_ack, z_m_err, z_m_rty, z_gnt;
  logic [31:0] z_m_dat_o, z_s_adr, z_s_dat_o;
  logic [3:0]  z_m_tgd_o, z_s_sel, z_s_tga, z_s_tgc, z_s_tgd_o;
  logic        z_s_cyc, z_s_stb, z_s_we, z_s_lock, z_tout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_M(2), .ADR_W(32), .DAT_W(32), .TAG_W(4), .TIMEOUT(16)) dut (
    .CLK_I(clk), .RST_I(rst_n),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_WE_I(m_we), .M_LOCK_I(m_lock),
    .M_ADR_I(m_adr), .M_DAT_I(m_dat), .M_SEL_I(m_sel),
    .M_TGA_I(m_tga), .M_TGC_I(m_tgc), .M_TGD_I(m_tgd),
    .M_ACK_O(m_ack), .M_ERR_O(m_err), .M_RTY_O(m_rty),
    .M_DAT_O(m_dat_o), .M_TGD_O(m_tgd_o),
    .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_LOCK_O(s_lock),
    .S_ADR_O(s_adr), .S_DAT_O(s_dat_o), .S_SEL_O(s_sel),
    .S_TGA_O(s_tga), .S_TGC_O(s_tgc), .S_TGD_O(s_tgd_o),
    .S_DAT_I(s_dat_i), .S_TGD_I(s_tgd_i),
    .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_RTY_I(s_rty),
    .GNT_O(gnt), .TIMEOUT_O(tout)
  );

  wb_arbiter #(.NUM_M(2), .ADR_W(32), .DAT_W(32), .TAG_W(4), .TIMEOUT(0)) dut0 (
    .CLK_I(clk), .RST_I(rst_n),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_WE_I(m_we), .M_LOCK_I(m_lock),
    .M_ADR_I(m_adr), .M_DAT_I(m_dat), .M_SEL_I(m_sel),
    .M_TGA_I(m_tga), .M_TGC_I(m_tgc), .M_TGD_I(m_tgd),
    .M_ACK_O(z_m_ack), .M_ERR_O(z_m_err), .M_RTY_O(z_m_rty),
    .M_DAT_O(z_m_dat_o), .M_TGD_O(z_m_tgd_o),
    .S_CYC_O(z_s_cyc), .S_STB_O(z_s_stb), .S_WE_O(z_s_we), .S_LOCK_O(z_s_lock),
    .S_ADR_O(z_s_adr), .S_DAT_O(z_s_dat_o), .S_SEL_O(z_s_sel),
    .S_TGA_O(z_s_tga), .S_TGC_O(z_s_tgc), .S_TGD_O(z_s_tgd_o),
    .S_DAT_I(s_dat_i), .S_TGD_I(s_tgd_i),
    .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_RTY_I(s_rty),
    .GNT_O(z_gnt), .TIMEOUT_O(z_tout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2ns after the next rising edge; inputs are driven there, outputs read 1ns later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int m, input logic on);
    m_cyc[m] = on;
    m_stb[m] = on;
  endtask

  initial begin
    logic [1:0] exp_g;
    int         own;

    rst_n = 1'b0;
    m_cyc = 2'($urandom_range(3)); m_stb = 2'($urandom_range(3));
    m_we = 2'($urandom_range(3));  m_lock = 2'($urandom_range(3));
    m_adr = {$urandom, $urandom};  m_dat = {$urandom, $urandom};
    m_sel = 8'($urandom); m_tga = 8'($urandom); m_tgc = 8'($urandom); m_tgd = 8'($urandom);
    s_dat_i = 32'h1234_5678; s_tgd_i = 4'h9;
    s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;
    step(); step(); #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_s_ctl", {s_cyc, s_stb, s_we, s_lock}, 0);
    chk("rst_terms", {m_ack, m_err, m_rty, tout}, 0);
    chk("rst_dat_follow", {m_dat_o, m_tgd_o}, {32'h1234_5678, 4'h9});
    $display("txn reset held: gnt=%b s_cyc=%b", gnt, s_cyc);

    m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
    m_adr = {32'h0000_0200, 32'h0000_0100};
    m_dat = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    m_sel = 8'h3F; m_tga = 8'h21; m_tgc = 8'h43; m_tgd = 8'h65;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    rst_n = 1'b1;

    // Fairness: both masters request; expected order 0,1,0,1 with an idle cycle between.
    step();
    req(0, 1'b1); req(1, 1'b1);
    #1 chk("arb_latency", gnt, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      own   = i % 2;
      exp_g = 2'b01 << own;
      s_ack = 1'b1;
      #1;
      chk("fair_gnt", gnt, exp_g);
      chk("fair_ack", m_ack, exp_g);
      chk("fair_adr", s_adr, (own == 1) ? 32'h200 : 32'h100);
      $display("txn fair %0d: gnt=%b adr=%h", i, gnt, s_adr);
      step();
      s_ack = 1'b0;
      req(own, 1'b0);
      #1;
      chk("fair_hold", gnt, exp_g);
      chk("fair_drop_cyc", s_cyc, 0);
      step();
      if (i < 3) req(own, 1'b1);
      else begin req(0, 1'b0); req(1, 1'b0); end
      #1 chk("fair_idle", gnt, 0);
      step();
    end
    #1 chk("fair_end", gnt, 0);

    // Single write from master 0.
    req(0, 1'b1); m_we[0] = 1'b1;
    #1 chk("wr_c0_gnt", gnt, 0);
    step(); #1;
    chk("wr_c1_gnt", gnt, 2'b01);
    chk("wr_c1_adr", s_adr, 32'h100);
    chk("wr_c1_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("wr_c1_ctl", {s_cyc, s_stb, s_we, s_lock}, 4'b1110);
    chk("wr_c1_tags", {s_sel, s_tga, s_tgc, s_tgd_o}, 16'hF135);
    step(); #1;
    chk("wr_c2_noack", m_ack, 0);
    step();
    s_ack = 1'b1;
    #1 chk("wr_c3_ack", m_ack, 2'b01);
    step();
    s_ack = 1'b0; req(0, 1'b0); m_we[0] = 1'b0;
    #1 chk("wr_c4_gnt", gnt, 2'b01);
    step(); #1;
    chk("wr_c5_gnt", gnt, 0);
    $display("txn write: adr=100 dat=deadbeef done");

    // LOCK: master 0 holds the bus with CYC low while master 1 requests.
    step();
    req(0, 1'b1); m_lock[0] = 1'b1;
    step();
    s_ack = 1'b1;
    #1;
    chk("lk_gnt", gnt, 2'b01);
    chk("lk_s_lock", s_lock, 1);
    chk("lk_ack0", m_ack, 2'b01);
    step();
    req(0, 1'b0); req(1, 1'b1);
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("lk_hold_gnt", gnt, 2'b01);
      chk("lk_hold_ack", m_ack, 0);
      chk("lk_hold_cyc", s_cyc, 0);
      step();
    end
    m_lock[0] = 1'b0; s_ack = 1'b0;
    #1 chk("lk_unlock_gnt", gnt, 2'b01);
    step(); #1;
    chk("lk_dead", gnt, 0);
    step();
    s_ack = 1'b1;
    #1;
    chk("lk_m1_gnt", gnt, 2'b10);
    chk("lk_m1_adr", s_adr, 32'h200);
    chk("lk_m1_ack", m_ack, 2'b10);
    $display("txn lock: master1 granted after unlock");
    step();
    s_ack = 1'b0; req(1, 1'b0);
    step(); #1;
    chk("lk_idle", gnt, 0);

    // Watchdog: slave never answers; STB first seen in cycle 1, abort in cycle 17.
    req(0, 1'b1);
    step(); #1;
    chk("to_c1_gnt", gnt, 2'b01);
    chk("to_c1_stb", s_stb, 1);
    for (int c = 1; c <= 16; c++) begin
      chk("to_quiet", {z_tout, z_m_err, tout, m_err}, 0);
      step(); #1;
    end
    chk("to_c17_err", m_err, 2'b01);
    chk("to_c17_tout", tout, 1);
    chk("to_c17_cyc", {s_cyc, s_stb}, 0);
    chk("to0_c17_err", z_m_err, 0);
    chk("to0_c17_cyc", {z_s_cyc, z_gnt}, 3'b101);
    $display("txn timeout: err=%b tout=%b", m_err, tout);
    step(); #1;
    chk("to_c18_clear", {tout, m_err}, 0);
    chk("to_c18_cyc", {s_cyc, gnt}, 3'b101);
    req(0, 1'b0);
    step(); #1;
    chk("to_release", gnt, 0);

    // ACK in the last counted cycle beats the watchdog.
    req(0, 1'b1);
    step();
    for (int c = 1; c <= 15; c++) step();
    s_ack = 1'b1;
    #1;
    chk("ta_c16_ack", m_ack, 2'b01);
    chk("ta_c16_tout", tout, 0);
    step();
    s_ack = 1'b0;
    #1;
    chk("ta_c17_noerr", {tout, m_err}, 0);
    chk("ta_c17_cyc", s_cyc, 1);
    req(0, 1'b0);
    step(); #1;
    chk("ta_release", gnt, 0);
    $display("txn ack-at-16: no timeout");

    // Reset while master 1 owns the bus.
    req(1, 1'b1);
    step();
    req(0, 1'b1);
    #1 chk("mr_m1_gnt", gnt, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_cyc", s_cyc, 0);
    chk("mr_async_gnt", gnt, 0);
    step(); step();
    rst_n = 1'b1;
    step(); #1;
    chk("mr_post_gnt", gnt, 2'b01);
    $display("txn reset mid-transfer: post-reset gnt=%b", gnt);
    req(0, 1'b0); req(1, 1'b0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin Wishbone B3 arbiter that shares one slave interface between NUM_M masters. It sits between the master-side and slave-side Wishbone interfaces in place of a direct point-to-point connection. It owns grant sequencing, LOCK-based bus holding, return-path steering, and a bus-timeout watchdog that terminates hung cycles with ERR.

## Interface
- NUM_M, 2: number of masters (2..4)
- ADR_W, 32: address width
- DAT_W, 32: data width; SEL_W = DAT_W/8
- TAG_W, 4: width of each of TGA, TGC and TGD
- TIMEOUT, 16: slave-response timeout in cycles; 0 disables the watchdog

Ports:
- CLK_I  in  1  clock; all state changes on the rising edge
- RST_I  in  1  reset, asynchronous, active-low
- M_CYC_I, M_STB_I, M_WE_I, M_LOCK_I  in  NUM_M each  per-master controls; bit i belongs to master i
- M_ADR_I  in  NUM_M*ADR_W  per-master address; slice i is master i
- M_DAT_I  in  NUM_M*DAT_W  per-master write data
- M_SEL_I  in  NUM_M*SEL_W  per-master byte selects
- M_TGA_I, M_TGC_I, M_TGD_I  in  NUM_M*TAG_W each  per-master tags
- M_ACK_O, M_ERR_O, M_RTY_O  out  NUM_M each  per-master terminations
- M_DAT_O  out  DAT_W  read data, broadcast to all masters
- M_TGD_O  out  TAG_W  read tag, broadcast to all masters
- S_CYC_O, S_STB_O, S_WE_O, S_LOCK_O  out  1 each  slave controls
- S_ADR_O  out  ADR_W  slave address
- S_DAT_O  out  DAT_W  slave write data
- S_SEL_O  out  SEL_W  slave byte selects
- S_TGA_O, S_TGC_O, S_TGD_O  out  TAG_W each  slave tags
- S_DAT_I  in  DAT_W  slave read data
- S_TGD_I  in  TAG_W  slave read tag
- S_ACK_I, S_ERR_I, S_RTY_I  in  1 each  slave terminations
- GNT_O  out  NUM_M  one-hot current grant; all zero when idle
- TIMEOUT_O  out  1  one-cycle pulse when the watchdog fires

## Operation
- States: IDLE and OWN. Registered state: gnt (one-hot), last (index of the most recently granted master), wdog counter (width $clog2(TIMEOUT+1)), abort flag.
- IDLE:
  - If any M_CYC_I bit is high, grant the first requester found searching from last+1, wrapping modulo NUM_M.
  - On grant, load gnt and last, and go to OWN.
  - If no M_CYC_I bit is high, stay in IDLE.
- OWN, forward path: S_* outputs are combinational muxes of the granted master's inputs.
  - S_CYC_O = M_CYC_I[g] & ~abort.
  - S_STB_O = M_STB_I[g] & M_CYC_I[g] & ~abort.
- OWN, return path:
  - M_ACK_O[g] = S_ACK_I & S_CYC_O. M_ERR_O and M_RTY_O are formed the same way.
  - M_ERR_O[g] is also forced high while abort is set.
  - Non-granted masters' terminations are 0.
  - M_DAT_O = S_DAT_I and M_TGD_O = S_TGD_I, always broadcast.
- Release: when M_CYC_I[g] = 0 and M_LOCK_I[g] = 0, clear gnt and return to IDLE. This costs one dead cycle before re-arbitration.
  - If the master drops CYC while LOCK is held high, the grant is kept and no other master is granted.
- Watchdog, active only when TIMEOUT != 0:
  - wdog increments each cycle S_STB_O = 1 with no termination.
  - wdog clears on any termination, when S_STB_O = 0, or on release.
  - When wdog = TIMEOUT-1 with no termination that cycle, set abort for exactly the next cycle.
  - While abort is set: M_ERR_O[g] = 1, TIMEOUT_O = 1, S_CYC_O = S_STB_O = 0, and slave terminations are masked.
  - abort then clears; the grant stays with the master until it releases.
- IDLE outputs: all S_* = 0, M_ACK_O/M_ERR_O/M_RTY_O = 0, GNT_O = 0.

## Timing
- Reset (RST_I low, asynchronous):
  - state = IDLE, gnt = 0, last = NUM_M-1 (master 0 has first priority), wdog = 0, abort = 0.
  - All outputs are 0 immediately, except M_DAT_O and M_TGD_O, which follow the slave.
  - Reset mid-transfer abandons the slave cycle with no termination returned.
- Arbitration latency: master asserts CYC in cycle t; GNT_O and S_CYC_O rise in cycle t+1.
- Terminations are combinational, with zero added latency from S_ACK_I to M_ACK_O.
- Handoff: master A drops CYC in cycle t; GNT_O = 0 in t+1; master B is granted in t+2.
- Watchdog: S_STB_O first high in cycle t with no termination through t+TIMEOUT-1 → abort, M_ERR_O and TIMEOUT_O high in cycle t+TIMEOUT only.
- A termination arriving in cycle t+TIMEOUT-1 wins, and no abort occurs.
- Simultaneous requests are resolved only by the round-robin pointer. The grant never changes while in OWN.

## Test plan
- Reset: hold RST_I low with random master inputs → GNT_O = 0, all S_* control outputs = 0, all M_ACK_O/M_ERR_O/M_RTY_O = 0. Release RST_I → master 0 wins the first contention.
- Single write: master 0 issues a write to ADR 0x100 with DAT 0xDEADBEEF in cycle 0 → GNT_O = 01 and S_ADR_O = 0x100 in cycle 1. Slave ACK in cycle 3 → M_ACK_O = 01 in cycle 3. Master drops CYC in cycle 4 → GNT_O = 00 in cycle 5.
- Fairness: both masters request continuously for 4 transactions → grant order 0, 1, 0, 1, with one idle cycle between grants.
- LOCK: master 0 drops CYC with LOCK = 1 for 5 cycles while master 1 requests → GNT_O stays 01 and M_ACK_O[1] stays 0. Master 0 drops LOCK → master 1 granted 2 cycles later.
- Timeout (TIMEOUT = 16): slave never terminates and STB is first seen in cycle 1 → in cycle 17, M_ERR_O = 01, TIMEOUT_O = 1 and S_CYC_O = 0, each for exactly one cycle. No watchdog fire if ACK arrives in cycle 16. With TIMEOUT = 0, no ERR is ever generated.
- Reset mid-transfer: assert RST_I while master 1 owns the bus → S_CYC_O and GNT_O go low without a clock edge. After reset, master 0 wins contention.
